// File: rtl/effect_param_sequencer.sv
// effect_param_sequencer: debounced key dispatch to effect parameters, with a serial divider for the tremolo rate
module effect_param_sequencer #(
   parameter int CLK_HZ          = 50000000,
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int TREM_DIV_INIT   = 2560,
   parameter int TREM_DIV_STEP   = 256,
   parameter int TREM_DIV_MIN    = 256,
   parameter int TREM_DIV_MAX    = 5120,
   parameter int ECHO_INIT       = 12000,
   parameter int ECHO_STEP       = 1000,
   parameter int ECHO_MIN        = 1000,
   parameter int ECHO_MAX        = 48000,
   parameter int DIST_INIT       = 16384,
   parameter int DIST_STEP       = 2048,
   parameter int DIST_MIN        = 2048,
   parameter int DIST_MAX        = 30720
) (
   input  logic        CLK,
   input  logic        RESET_N,
   input  logic        key3,
   input  logic        key2,
   input  logic [9:0]  SW,
   output logic [15:0] echo_delay,
   output logic [15:0] dist_threshold,
   output logic [12:0] trem_divisor,
   output logic [31:0] trem_frequency,
   output logic        freq_valid,
   output logic        busy,
   output logic [2:0]  disabled
);
   localparam int          CW        = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [31:0] DIVIDEND  = 32'(CLK_HZ);
   localparam logic [31:0] FREQ_INIT = 32'(CLK_HZ / TREM_DIV_INIT);
   typedef enum logic [1:0] {IDLE, DIV, DONE} state_t;
   state_t         state;
   logic [1:0]     sync1, sync2, deb, ev;
   logic [CW-1:0]  cnt [2];
   logic           up, dn, e_up, e_dn, d_up, d_dn;
   logic           t_key, t_take_q, t_ev, t_sub, t_ok, t_go;
   logic [12:0]    t_nx, dv;
   logic           q_valid, q_sub, q_bit;
   logic [31:0]    rem, quo, r_sh, r_nx;
   logic [4:0]     it;
   logic           unused_sw;
   assign unused_sw = ^SW[6:4];
   // two-flop synchronisers for the raw keys; bit 1 is key3, bit 0 is key2, idle high
   always_ff @(posedge CLK or negedge RESET_N)
      if (!RESET_N) begin
         sync1 <= 2'b11;
         sync2 <= 2'b11;
      end else begin
         sync1 <= {key3, key2};
         sync2 <= sync1;
      end
   // debounce: flip the pressed state after a full run of disagreeing samples, pulse on press only
   always_ff @(posedge CLK or negedge RESET_N)
      if (!RESET_N) begin
         deb    <= '0;
         ev     <= '0;
         cnt[0] <= '0;
         cnt[1] <= '0;
      end else begin
         for (int i = 0; i < 2; i++) begin
            ev[i] <= 1'b0;
            if (~sync2[i] != deb[i]) begin
               if (cnt[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
                  deb[i] <= ~sync2[i];
                  ev[i]  <= ~sync2[i];
                  cnt[i] <= '0;
               end else
                  cnt[i] <= cnt[i] + 1'b1;
            end else
               cnt[i] <= '0;
         end
      end
   assign up   = ev[1] & ~ev[0];
   assign dn   = ev[0] & ~ev[1];
   assign e_up = SW[3:0] == 4'd1 && up && int'(echo_delay) + ECHO_STEP <= ECHO_MAX;
   assign e_dn = SW[3:0] == 4'd1 && dn && int'(echo_delay) - ECHO_STEP >= ECHO_MIN;
   assign d_up = SW[3:0] == 4'd3 && up && int'(dist_threshold) + DIST_STEP <= DIST_MAX;
   assign d_dn = SW[3:0] == 4'd3 && dn && int'(dist_threshold) - DIST_STEP >= DIST_MIN;
   // a queued tremolo request takes priority in DONE; a fresh key request is used whenever the divider is not running
   assign t_key    = SW[3:0] == 4'd2 && (up | dn);
   assign t_take_q = state == DONE && q_valid;
   assign t_ev     = t_take_q || (state != DIV && t_key);
   assign t_sub    = t_take_q ? q_sub : up;
   assign t_ok     = t_sub ? int'(trem_divisor) - TREM_DIV_STEP >= TREM_DIV_MIN
                           : int'(trem_divisor) + TREM_DIV_STEP <= TREM_DIV_MAX;
   assign t_go     = t_ev && t_ok;
   assign t_nx     = t_sub ? trem_divisor - 13'(TREM_DIV_STEP) : trem_divisor + 13'(TREM_DIV_STEP);
   // one restoring step: shift in the next dividend bit, subtract the divisor when it fits
   assign r_sh  = {rem[30:0], quo[31]};
   assign q_bit = r_sh >= 32'(dv);
   assign r_nx  = q_bit ? r_sh - 32'(dv) : r_sh;
   // live parameter registers and the registered bypass flags
   always_ff @(posedge CLK or negedge RESET_N)
      if (!RESET_N) begin
         echo_delay     <= 16'(ECHO_INIT);
         dist_threshold <= 16'(DIST_INIT);
         trem_divisor   <= 13'(TREM_DIV_INIT);
         disabled       <= 3'b111;
      end else begin
         echo_delay     <= e_up ? echo_delay + 16'(ECHO_STEP) : e_dn ? echo_delay - 16'(ECHO_STEP) : echo_delay;
         dist_threshold <= d_up ? dist_threshold + 16'(DIST_STEP) : d_dn ? dist_threshold - 16'(DIST_STEP) : dist_threshold;
         trem_divisor   <= t_go ? t_nx : trem_divisor;
         disabled       <= ~SW[9:7];
      end
   // one-deep tremolo queue: filled while dividing, drained in DONE; a request arriving with the slot taken is dropped
   always_ff @(posedge CLK or negedge RESET_N)
      if (!RESET_N) begin
         q_valid <= 1'b0;
         q_sub   <= 1'b0;
      end else if (t_take_q)
         q_valid <= 1'b0;
      else if (state == DIV && t_key && !q_valid) begin
         q_valid <= 1'b1;
         q_sub   <= up;
      end
   // divider sequencer: start on an accepted divisor change, 32 iterations, publish the quotient in DONE
   always_ff @(posedge CLK or negedge RESET_N)
      if (!RESET_N) begin
         state          <= IDLE;
         busy           <= 1'b0;
         freq_valid     <= 1'b0;
         trem_frequency <= FREQ_INIT;
         rem            <= '0;
         quo            <= '0;
         dv             <= '0;
         it             <= '0;
      end else begin
         freq_valid <= 1'b0;
         case (state)
            DIV: begin
               rem <= r_nx;
               quo <= {quo[30:0], q_bit};
               it  <= it + 5'd1;
               if (it == 5'd31) begin
                  state          <= DONE;
                  busy           <= 1'b0;
                  freq_valid     <= 1'b1;
                  trem_frequency <= {quo[30:0], q_bit};
               end
            end
            default: begin
               state <= t_go ? DIV : IDLE;
               busy  <= t_go;
               if (t_go) begin
                  rem <= '0;
                  quo <= DIVIDEND;
                  dv  <= t_nx;
                  it  <= '0;
               end
            end
         endcase
      end
endmodule

// File: tb/tb_effect_param_sequencer.sv
// tb_effect_param_sequencer: directed checks of key dispatch, clamping, divider timing, queueing and reset
module tb_effect_param_sequencer;
   localparam int DB = 4;
   logic        CLK = 1'b0, RESET_N = 1'b0, key3 = 1'b1, key2 = 1'b1;
   logic [9:0]  SW = '0;
   logic [15:0] echo_delay, dist_threshold;
   logic [12:0] trem_divisor;
   logic [31:0] trem_frequency;
   logic        freq_valid, busy;
   logic [2:0]  disabled;
   int          n_cmp = 0, n_bad = 0, fv_total = 0, busy_total = 0, fv0, b0;

   effect_param_sequencer #(.DEBOUNCE_CYCLES(DB)) dut (
      .CLK(CLK), .RESET_N(RESET_N), .key3(key3), .key2(key2), .SW(SW),
      .echo_delay(echo_delay), .dist_threshold(dist_threshold), .trem_divisor(trem_divisor),
      .trem_frequency(trem_frequency), .freq_valid(freq_valid), .busy(busy), .disabled(disabled)
   );

   always #5 CLK = ~CLK;

   always @(negedge CLK) begin
      if (freq_valid) fv_total++;
      if (busy) busy_total++;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge CLK);
   endtask

   task automatic press(input logic k3, input logic k2, input int hold);
      key3 = ~k3;
      key2 = ~k2;
      cyc(hold);
      key3 = 1'b1;
      key2 = 1'b1;
      cyc(DB + 4);
   endtask

   task automatic tap3();
      key3 = 1'b0;
      cyc(DB + 2);
      key3 = 1'b1;
      cyc(DB + 2);
   endtask

   task automatic wait_busy(input string tag);
      int t = 0;
      while (!busy && t < 50) begin cyc(1); t++; end
      check(tag, busy, 1);
   endtask

   task automatic wait_idle(input string tag);
      int t = 0;
      while (busy && t < 200) begin cyc(1); t++; end
      check(tag, busy, 0);
      cyc(2);
   endtask

   task automatic wait_fv(input string tag);
      int t = 0;
      while (!freq_valid && t < 200) begin cyc(1); t++; end
      check(tag, freq_valid, 1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      cyc(3);
      RESET_N = 1'b1;
      cyc(2);
      check("rst_echo", echo_delay, 12000);
      check("rst_dist", dist_threshold, 16384);
      check("rst_div", trem_divisor, 2560);
      check("rst_freq", trem_frequency, 19531);
      check("rst_busy", busy, 0);
      check("rst_fv", freq_valid, 0);
      check("rst_dis", disabled, 3'b111);
      SW = 10'b101_000_0000;
      cyc(2);
      check("dis_101", disabled, 3'b010);
      SW = 10'b111_000_0010;
      cyc(2);
      check("dis_111", disabled, 3'b000);

      // clean held key3 on tremolo
      fv0 = fv_total; b0 = busy_total;
      key3 = 1'b0;
      wait_busy("t2_busy");
      check("t2_div", trem_divisor, 2304);
      check("t2_freq_hold", trem_frequency, 19531);
      cyc(40);
      key3 = 1'b1;
      cyc(DB + 4);
      check("t2_div_once", trem_divisor, 2304);
      check("t2_freq", trem_frequency, 21701);
      check("t2_busy_cycles", busy_total - b0, 32);
      check("t2_fv_pulses", fv_total - fv0, 1);

      // bouncing key2 on echo
      SW = 10'b111_000_0001;
      for (int i = 0; i < 15; i++) begin key2 = i[0]; cyc(2); end
      cyc(20);
      key2 = 1'b1;
      cyc(DB + 4);
      check("t3_echo", echo_delay, 11000);
      check("t3_div_same", trem_divisor, 2304);
      SW = 10'b111_000_0011;
      press(1, 0, DB + 6);
      check("dist_up", dist_threshold, 18432);
      press(0, 1, DB + 6);
      check("dist_dn", dist_threshold, 16384);
      SW = 10'b111_000_0000;
      press(1, 0, DB + 6);
      check("sel0_echo", echo_delay, 11000);
      check("sel0_div", trem_divisor, 2304);

      // clamp at the tremolo limits
      SW = 10'b111_000_0010;
      for (int i = 0; i < 11; i++) begin press(0, 1, DB + 4); wait_idle("t4_up_idle"); end
      check("t4_div_max", trem_divisor, 5120);
      check("t4_freq_max", trem_frequency, 9765);
      fv0 = fv_total; b0 = busy_total;
      press(0, 1, DB + 4);
      cyc(40);
      check("t4_div_hold_max", trem_divisor, 5120);
      check("t4_nobusy_max", busy_total - b0, 0);
      check("t4_nofv_max", fv_total - fv0, 0);
      for (int i = 0; i < 19; i++) begin press(1, 0, DB + 4); wait_idle("t4_dn_idle"); end
      check("t4_div_min", trem_divisor, 256);
      check("t4_freq_min", trem_frequency, 195312);
      fv0 = fv_total; b0 = busy_total;
      press(1, 0, DB + 4);
      cyc(40);
      check("t4_div_hold_min", trem_divisor, 256);
      check("t4_nobusy_min", busy_total - b0, 0);
      check("t4_nofv_min", fv_total - fv0, 0);

      // reset in the middle of a division
      key2 = 1'b0;
      wait_busy("t6_busy");
      cyc(10);
      check("t6_mid_busy", busy, 1);
      check("t6_mid_div", trem_divisor, 512);
      #1 RESET_N = 1'b0;
      #1;
      check("t6_rst_div", trem_divisor, 2560);
      check("t6_rst_freq", trem_frequency, 19531);
      check("t6_rst_busy", busy, 0);
      check("t6_rst_echo", echo_delay, 12000);
      check("t6_rst_dis", disabled, 3'b111);
      key2 = 1'b1;
      cyc(3);
      RESET_N = 1'b1;
      fv0 = fv_total;
      cyc(40);
      check("t6_after_freq", trem_frequency, 19531);
      check("t6_after_fv", fv_total - fv0, 0);

      // queued tremolo press during a division, third press dropped
      fv0 = fv_total;
      tap3();
      tap3();
      tap3();
      wait_fv("t5_fv1");
      check("t5_freq1", trem_frequency, 21701);
      cyc(1);
      check("t5_restart_busy", busy, 1);
      check("t5_restart_div", trem_divisor, 2048);
      wait_fv("t5_fv2");
      check("t5_freq2", trem_frequency, 24414);
      cyc(5);
      check("t5_div_final", trem_divisor, 2048);
      check("t5_fv_count", fv_total - fv0, 2);
      check("t5_idle", busy, 0);

      // simultaneous presses are discarded
      SW = 10'b111_000_0001;
      press(1, 1, DB + 6);
      check("both_echo", echo_delay, 12000);
      SW = 10'b111_000_0010;
      b0 = busy_total;
      press(1, 1, DB + 6);
      cyc(10);
      check("both_div", trem_divisor, 2048);
      check("both_nobusy", busy_total - b0, 0);
      SW = 10'b111_000_0011;
      press(1, 1, DB + 6);
      check("both_dist", dist_threshold, 16384);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
